// File: rtl/adc_rx_pkg.sv
// Shared definitions for the ADC LVDS receive path: alignment FSM state
// encoding, frame/sample widths and the frame-sync training patterns.
package adc_rx_pkg;

  localparam int ADC_FRAME_W  = 7;
  localparam int ADC_SAMPLE_W = 14;

  // The frame-sync lane idles at all-0 or all-1 when the word boundary is right.
  localparam logic [ADC_FRAME_W-1:0] ADC_FRAME_ALL0 = '0;
  localparam logic [ADC_FRAME_W-1:0] ADC_FRAME_ALL1 = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SLIP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOCKED = 3'd4,
    ST_FAULT  = 3'd5
  } adc_align_state_t;

endpackage

// File: rtl/adc_align_ctrl_if.sv
// Link between the alignment controller and the deserializer wrapper /
// sample write path. The controller is the master: it owns the slip and
// reset requests and the status outputs.
interface adc_align_ctrl_if
  import adc_rx_pkg::*;
#(
  parameter int FRAME_W = ADC_FRAME_W
) ();

  logic               enable;
  logic [FRAME_W-1:0] frame_sync;
  logic               bitslip;
  logic               io_reset_req;
  logic               locked;
  logic [3:0]         slip_count;
  logic [3:0]         retry_count;
  logic [7:0]         lock_loss_count;
  logic [2:0]         state_dbg;

  modport master (
    input  enable,
    input  frame_sync,
    output bitslip,
    output io_reset_req,
    output locked,
    output slip_count,
    output retry_count,
    output lock_loss_count,
    output state_dbg
  );

  modport slave (
    output enable,
    output frame_sync,
    input  bitslip,
    input  io_reset_req,
    input  locked,
    input  slip_count,
    input  retry_count,
    input  lock_loss_count,
    input  state_dbg
  );

endinterface

// File: rtl/adc_align_ctrl_frame_check.sv
// Combinational frame-sync classifier. A frame is good when the sync lane
// reads all-0 or all-1; anything else means the word boundary is off.
module adc_frame_check
  import adc_rx_pkg::*;
#(
  parameter int FRAME_W = ADC_FRAME_W
) (
  input  logic [FRAME_W-1:0] frame_sync,
  output logic               good
);

  // Pure pattern match, no state.
  assign good = (frame_sync == {FRAME_W{1'b0}}) || (frame_sync == {FRAME_W{1'b1}});

endmodule

// File: rtl/adc_align_ctrl.sv
// Frame-alignment controller: slips the deserializer until the frame-sync
// word is stable, declares lock after a run of good frames, drops lock on a
// run of bad frames and escalates to a deserializer IO reset when a full
// slip sweep fails.
module adc_align_ctrl
  import adc_rx_pkg::*;
#(
  parameter int FRAME_W       = ADC_FRAME_W,
  parameter int SETTLE_CYCLES = 4,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int MAX_SLIPS     = 7,
  parameter int RESET_HOLD    = 8
) (
  input  logic             clk_adc,
  input  logic             reset,
  adc_align_ctrl_if.master bus
);

  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_COUNT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(RESET_HOLD - 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  adc_align_state_t state_q, state_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic [3:0] bad_cnt_q, bad_cnt_d;
  logic [3:0] slip_cnt_q, slip_cnt_d;
  logic [3:0] retry_cnt_q, retry_cnt_d;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  // Shared down-counter: settle time in WAIT, reset hold time in FAULT.
  logic [7:0] timer_q, timer_d;
  logic       bitslip_q, bitslip_d;
  logic       io_reset_req_q, io_reset_req_d;
  logic       locked_q, locked_d;
  logic       frame_good;

  adc_frame_check #(.FRAME_W(FRAME_W)) u_frame_check (
    .frame_sync (bus.frame_sync),
    .good       (frame_good)
  );

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    slip_cnt_d  = slip_cnt_q;
    retry_cnt_d = retry_cnt_q;
    loss_cnt_d  = loss_cnt_q;
    timer_d     = timer_q;

    if (!bus.enable) begin
      state_d     = ST_IDLE;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      slip_cnt_d  = '0;
      retry_cnt_d = '0;
      timer_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_CHECK;
          good_cnt_d  = '0;
          bad_cnt_d   = '0;
          slip_cnt_d  = '0;
          retry_cnt_d = '0;
        end
        ST_CHECK: begin
          if (frame_good) begin
            if (good_cnt_q == LOCK_LAST) begin
              state_d    = ST_LOCKED;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 8'd1;
            end
          end else begin
            good_cnt_d = '0;
            // A whole sweep of slips found no boundary: reset the IO block.
            if (slip_cnt_q == SLIP_MAX) begin
              state_d     = ST_FAULT;
              timer_d     = HOLD_LOAD;
              retry_cnt_d = sat_inc4(retry_cnt_q);
            end else begin
              state_d = ST_SLIP;
            end
          end
        end
        ST_SLIP: begin
          state_d    = ST_WAIT;
          slip_cnt_d = slip_cnt_q + 4'd1;
          timer_d    = SETTLE_LOAD;
        end
        ST_WAIT: begin
          // The deserializer output is unreliable right after a slip/reset.
          if (timer_q == 8'd0) begin
            state_d    = ST_CHECK;
            good_cnt_d = '0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_LOCKED: begin
          if (frame_good) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q == UNLOCK_LAST) begin
            state_d    = ST_CHECK;
            bad_cnt_d  = '0;
            good_cnt_d = '0;
            slip_cnt_d = '0;
            loss_cnt_d = sat_inc8(loss_cnt_q);
          end else begin
            bad_cnt_d = bad_cnt_q + 4'd1;
          end
        end
        ST_FAULT: begin
          if (timer_q == 8'd0) begin
            state_d    = ST_WAIT;
            slip_cnt_d = '0;
            timer_d    = SETTLE_LOAD;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    bitslip_d      = (state_d == ST_SLIP);
    io_reset_req_d = (state_d == ST_FAULT);
    locked_d       = (state_d == ST_LOCKED);
  end

  // State, counters and outputs; asynchronous reset cuts io_reset_req at once.
  always_ff @(posedge clk_adc or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      slip_cnt_q     <= '0;
      retry_cnt_q    <= '0;
      loss_cnt_q     <= '0;
      timer_q        <= '0;
      bitslip_q      <= 1'b0;
      io_reset_req_q <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      bad_cnt_q      <= bad_cnt_d;
      slip_cnt_q     <= slip_cnt_d;
      retry_cnt_q    <= retry_cnt_d;
      loss_cnt_q     <= loss_cnt_d;
      timer_q        <= timer_d;
      bitslip_q      <= bitslip_d;
      io_reset_req_q <= io_reset_req_d;
      locked_q       <= locked_d;
    end
  end

  assign bus.bitslip         = bitslip_q;
  assign bus.io_reset_req    = io_reset_req_q;
  assign bus.locked          = locked_q;
  assign bus.slip_count      = slip_cnt_q;
  assign bus.retry_count     = retry_cnt_q;
  assign bus.lock_loss_count = loss_cnt_q;
  assign bus.state_dbg       = state_q;

endmodule

// File: tb/tb_adc_align_ctrl.sv
// Bench for adc_align_ctrl: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_adc_align_ctrl;
  import adc_rx_pkg::*;

  localparam int SETTLE = 4;
  localparam int LOCKN  = 16;
  localparam int UNLOCK = 4;
  localparam int MAXS   = 7;
  localparam int HOLD   = 8;

  localparam int S_IDLE = 0, S_CHECK = 1, S_SLIP = 2, S_WAIT = 3, S_LOCKED = 4, S_FAULT = 5;

  logic clk_adc = 1'b0;
  logic reset;
  always #5 clk_adc = ~clk_adc;

  adc_align_ctrl_if #(.FRAME_W(ADC_FRAME_W)) bus ();

  adc_align_ctrl #(
    .FRAME_W(ADC_FRAME_W), .SETTLE_CYCLES(SETTLE), .LOCK_COUNT(LOCKN),
    .UNLOCK_COUNT(UNLOCK), .MAX_SLIPS(MAXS), .RESET_HOLD(HOLD)
  ) dut (
    .clk_adc (clk_adc),
    .reset   (reset),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase plus counters, stepped once per clock edge.
  int m_phase, m_run_good, m_run_bad, m_slips, m_retries, m_losses, m_left;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit frame_is_good(input logic [ADC_FRAME_W-1:0] f);
    return (f == ADC_FRAME_ALL0) || (f == ADC_FRAME_ALL1);
  endfunction

  task automatic model_reset();
    m_phase = S_IDLE; m_run_good = 0; m_run_bad = 0;
    m_slips = 0; m_retries = 0; m_losses = 0; m_left = 0;
  endtask

  task automatic model_step(input logic en, input logic [ADC_FRAME_W-1:0] fs);
    bit g;
    g = frame_is_good(fs);
    if (!en) begin
      m_phase = S_IDLE; m_run_good = 0; m_run_bad = 0; m_slips = 0; m_retries = 0;
      return;
    end
    case (m_phase)
      S_IDLE: begin
        m_phase = S_CHECK; m_run_good = 0; m_run_bad = 0; m_slips = 0; m_retries = 0;
      end
      S_CHECK: begin
        if (g) begin
          m_run_good++;
          if (m_run_good == LOCKN) begin m_phase = S_LOCKED; m_run_bad = 0; end
        end else begin
          m_run_good = 0;
          if (m_slips == MAXS) begin
            m_phase = S_FAULT; m_left = HOLD;
            if (m_retries < 15) m_retries++;
          end else begin
            m_phase = S_SLIP;
          end
        end
      end
      S_SLIP: begin m_slips++; m_phase = S_WAIT; m_left = SETTLE; end
      S_WAIT: begin
        m_left--;
        if (m_left == 0) begin m_phase = S_CHECK; m_run_good = 0; end
      end
      S_LOCKED: begin
        if (g) m_run_bad = 0;
        else begin
          m_run_bad++;
          if (m_run_bad == UNLOCK) begin
            m_phase = S_CHECK; m_run_bad = 0; m_run_good = 0; m_slips = 0;
            if (m_losses < 255) m_losses++;
          end
        end
      end
      S_FAULT: begin
        m_left--;
        if (m_left == 0) begin m_phase = S_WAIT; m_left = SETTLE; m_slips = 0; end
      end
      default: m_phase = S_IDLE;
    endcase
  endtask

  task automatic compare_model();
    check("state_dbg", bus.state_dbg, m_phase);
    check("bitslip", bus.bitslip, m_phase == S_SLIP);
    check("io_reset_req", bus.io_reset_req, m_phase == S_FAULT);
    check("locked", bus.locked, m_phase == S_LOCKED);
    check("slip_count", bus.slip_count, m_slips);
    check("retry_count", bus.retry_count, m_retries);
    check("lock_loss_count", bus.lock_loss_count, m_losses);
  endtask

  // One clock: model sees the same inputs the DUT samples, outputs checked 1ns later.
  task automatic cycle();
    @(posedge clk_adc);
    model_step(bus.enable, bus.frame_sync);
    #1;
    compare_model();
  endtask

  initial begin
    int pulses, gap, min_gap, chk_run, hold_len, waits, entries;
    logic prev_io;
    int mode;

    reset = 1'b1;
    bus.enable = 1'b0;
    bus.frame_sync = ADC_FRAME_ALL0;
    model_reset();
    repeat (3) @(posedge clk_adc);
    #1;
    check("rst_bitslip", bus.bitslip, 0);
    check("rst_io_reset_req", bus.io_reset_req, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_slip_count", bus.slip_count, 0);
    check("rst_retry_count", bus.retry_count, 0);
    check("rst_lock_loss", bus.lock_loss_count, 0);
    check("rst_state", bus.state_dbg, 0);
    reset = 1'b0;

    // Lock after two slips.
    bus.enable = 1'b1;
    bus.frame_sync = 7'b0011100;
    pulses = 0; gap = 0; min_gap = 1000; chk_run = 0;
    for (int i = 0; i < 200 && !bus.locked; i++) begin
      cycle();
      if (bus.bitslip) begin
        pulses++;
        if (pulses > 1 && gap < min_gap) min_gap = gap;
        gap = 0;
        if (pulses == 2) bus.frame_sync = ADC_FRAME_ALL1;
      end else begin
        gap++;
      end
      if (!bus.locked) chk_run = (bus.state_dbg == 3'd1) ? chk_run + 1 : 0;
    end
    check("lock_reached", bus.locked, 1);
    check("lock_slip_pulses", pulses, 2);
    check("lock_slip_gap_ge_settle", min_gap >= SETTLE, 1);
    check("lock_good_run", chk_run, LOCKN);
    check("lock_slip_count", bus.slip_count, 2);
    check("lock_state", bus.state_dbg, 4);

    // Unlock: 3 bad, 1 good, 4 bad.
    bus.frame_sync = 7'b0011100;
    for (int k = 0; k < 3; k++) begin cycle(); check("unlock_burst1_locked", bus.locked, 1); end
    bus.frame_sync = ADC_FRAME_ALL0;
    cycle();
    check("unlock_good_locked", bus.locked, 1);
    bus.frame_sync = 7'b1000001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("unlock_burst2_locked", bus.locked, (k < 3) ? 1 : 0);
    end
    check("unlock_loss_count", bus.lock_loss_count, 1);
    check("unlock_state", bus.state_dbg, 1);

    // FAULT escalation from a clean sweep.
    bus.enable = 1'b0;
    cycle();
    bus.enable = 1'b1;
    bus.frame_sync = 7'b0101010;
    pulses = 0;
    for (int i = 0; i < 500 && !bus.io_reset_req; i++) begin
      cycle();
      if (bus.bitslip) pulses++;
    end
    check("fault_entered", bus.io_reset_req, 1);
    check("fault_slip_pulses", pulses, MAXS);
    hold_len = bus.io_reset_req ? 1 : 0;
    for (int i = 0; i < 50 && bus.io_reset_req; i++) begin
      cycle();
      if (bus.io_reset_req) hold_len++;
    end
    check("fault_hold_len", hold_len, HOLD);
    check("fault_retry_count", bus.retry_count, 1);
    check("fault_slip_cleared", bus.slip_count, 0);
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.bitslip) break;
      if (bus.state_dbg == 3'd3) waits++;
      cycle();
    end
    check("fault_settle_cycles", waits, SETTLE);
    check("fault_sweep_restart", bus.bitslip, 1);

    // Enable drop while in SLIP.
    bus.enable = 1'b0;
    cycle();
    check("endrop_bitslip", bus.bitslip, 0);
    check("endrop_state", bus.state_dbg, 0);
    check("endrop_slip_count", bus.slip_count, 0);
    check("endrop_loss_kept", bus.lock_loss_count, 1);

    // Asynchronous reset while io_reset_req is high.
    bus.enable = 1'b1;
    for (int i = 0; i < 500 && !bus.io_reset_req; i++) cycle();
    check("areset_io_before", bus.io_reset_req, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("areset_io_cut", bus.io_reset_req, 0);
    compare_model();
    @(posedge clk_adc);
    #1 reset = 1'b0;

    // Retry counter saturation over 17 FAULT entries.
    entries = 0; prev_io = 1'b0;
    for (int i = 0; i < 5000 && entries < 17; i++) begin
      cycle();
      if (bus.io_reset_req && !prev_io) begin
        entries++;
        check("sat_retry_step", bus.retry_count, (entries < 15) ? entries : 15);
      end
      prev_io = bus.io_reset_req;
    end
    check("sat_entries", entries, 17);
    check("sat_retry_final", bus.retry_count, 15);

    // Randomized traffic against the model.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      bus.enable = ($urandom_range(0, 199) != 0);
      case (mode)
        0: bus.frame_sync = ($urandom_range(0, 19) != 0) ?
                            (($urandom_range(0, 1) != 0) ? ADC_FRAME_ALL1 : ADC_FRAME_ALL0) :
                            ADC_FRAME_W'($urandom);
        1: bus.frame_sync = ADC_FRAME_W'($urandom);
        default: bus.frame_sync = ($urandom_range(0, 1) != 0) ? ADC_FRAME_ALL1 : ADC_FRAME_ALL0;
      endcase
      cycle();
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1'b1;
        #1;
        model_reset();
        compare_model();
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
